// File: rtl/dot_engine_scheduler.sv
// Schedules one shared dot-product engine across NUM_NEURONS output neurons.
// For each neuron it pulses engine_clear, streams ROWS row addresses to the
// pixel/weight memories, strobes the engine one cycle later (aligned with the
// memory read data), waits for engine_done, and captures the result. After
// the last neuron it reports the argmax class. A WAIT that lasts TIMEOUT
// cycles ends the run with the sticky error flag set.
//
// Ports:
//   clk, GlobalReset           clock, asynchronous active-low reset
//   start / busy / done        run handshake with the classifier FSM
//   error                      sticky timeout flag, cleared by the next start
//   row_addr, neuron_idx       memory row address and weight bank select
//   engine_clear               accumulator clear pulse before each neuron
//   engine_row_valid           row beat strobe, one cycle after row_addr
//   engine_done/engine_result  engine result handshake
//   result_valid/result_data   per-neuron captured result
//   class_out/class_valid      argmax neuron index after a clean run
module dot_engine_scheduler #(
    parameter int unsigned ROWS        = 28,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned RESULT_W    = 26,
    parameter int unsigned TIMEOUT     = 512
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [4:0]          row_addr,
    output logic [3:0]          neuron_idx,
    output logic                engine_clear,
    output logic                engine_row_valid,
    input  logic                engine_done,
    input  logic [RESULT_W-1:0] engine_result,
    output logic                result_valid,
    output logic [RESULT_W-1:0] result_data,
    output logic [3:0]          class_out,
    output logic                class_valid
);

    localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StWait, StCapture, StFin} state_e;

    state_e              state_q, state_d;
    logic [4:0]          row_q, row_d;
    logic [3:0]          neuron_q, neuron_d;
    logic [ToW-1:0]      to_q, to_d;
    logic                error_q, error_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [RESULT_W-1:0] max_q, max_d;
    logic [3:0]          class_q, class_d;
    logic                class_valid_q, class_valid_d;
    logic                row_valid_q;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q       <= StIdle;
            row_q         <= '0;
            neuron_q      <= '0;
            to_q          <= '0;
            error_q       <= 1'b0;
            result_q      <= '0;
            max_q         <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            row_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            neuron_q      <= neuron_d;
            to_q          <= to_d;
            error_q       <= error_d;
            result_q      <= result_d;
            max_q         <= max_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            // An address issued in FEED returns memory data one cycle later.
            row_valid_q   <= (state_q == StFeed);
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        neuron_d      = neuron_q;
        to_d          = to_q;
        error_d       = error_q;
        result_d      = result_q;
        max_d         = max_q;
        class_d       = class_q;
        class_valid_d = class_valid_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StClear;
                    neuron_d      = '0;
                    error_d       = 1'b0;
                    class_valid_d = 1'b0;
                end
            end
            StClear: begin
                row_d   = '0;
                state_d = StFeed;
            end
            StFeed: begin
                if (row_q == 5'(ROWS - 1)) begin
                    row_d   = '0;
                    to_d    = '0;
                    state_d = StWait;
                end else begin
                    row_d = row_q + 5'd1;
                end
            end
            StWait: begin
                if (engine_done) begin
                    result_d = engine_result;
                    state_d  = StCapture;
                end else if (to_q == ToW'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = StFin;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StCapture: begin
                // Strictly greater keeps the lower index on ties.
                if ((neuron_q == 4'd0) || ($signed(result_q) > $signed(max_q))) begin
                    max_d   = result_q;
                    class_d = neuron_q;
                end
                if (neuron_q == 4'(NUM_NEURONS - 1)) begin
                    class_valid_d = 1'b1;
                    state_d       = StFin;
                end else begin
                    neuron_d = neuron_q + 4'd1;
                    state_d  = StClear;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy             = (state_q == StClear) || (state_q == StFeed) ||
                              (state_q == StWait)  || (state_q == StCapture);
    assign done             = (state_q == StFin);
    assign engine_clear     = (state_q == StClear);
    assign result_valid     = (state_q == StCapture);
    assign error            = error_q;
    assign row_addr         = row_q;
    assign neuron_idx       = neuron_q;
    assign engine_row_valid = row_valid_q;
    assign result_data      = result_q;
    assign class_out        = class_q;
    assign class_valid      = class_valid_q;

endmodule
